// File: rtl/fan_pwm_multi_ctrl.sv
// fan_pwm_multi_ctrl
//
// Multi-channel PWM generator for fans and LEDs. One prescaler and one period
// counter are shared by every channel. Each channel has its own enable, duty
// target, kick-start phase (full-on for KickPeriods periods after enable) and
// a soft duty ramp of at most RampStep ticks per period boundary.
//
// All channel state changes only on a period boundary. Changes to enable,
// duty or period in the middle of a period therefore never produce a glitch.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   prescale_i     a tick occurs every prescale_i+1 clock cycles
//   period_i       PWM period is period_i+1 ticks, sampled at each boundary
//   en_i           per-channel enable, sampled at each boundary
//   duty_i         per-channel duty target in ticks, channel 0 at the LSBs
//   pwm_o          registered PWM outputs
//   busy_o         channel is not OFF
//   ramp_done_o    channel is in RUN and its duty has reached duty_i
//   period_start_o one-cycle pulse in the cycle after each period boundary
module fan_pwm_multi_ctrl #(
    parameter int NumChannels = 2,
    parameter int CntWidth    = 8,
    parameter int PscWidth    = 8,
    parameter int KickPeriods = 4,
    parameter int RampStep    = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [PscWidth-1:0]             prescale_i,
    input  logic [CntWidth-1:0]             period_i,
    input  logic [NumChannels-1:0]          en_i,
    input  logic [NumChannels*CntWidth-1:0] duty_i,
    output logic [NumChannels-1:0]          pwm_o,
    output logic [NumChannels-1:0]          busy_o,
    output logic [NumChannels-1:0]          ramp_done_o,
    output logic                            period_start_o
);

    localparam int KickW = (KickPeriods > 1) ? $clog2(KickPeriods) : 1;
    localparam logic [KickW-1:0] KickLast =
        (KickPeriods > 0) ? KickW'(KickPeriods - 1) : '0;
    localparam logic [CntWidth:0] StepX = (CntWidth + 1)'(RampStep);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_KICK = 2'd1,
        ST_RUN  = 2'd2
    } ch_state_e;

    // Move cur toward tgt by at most RampStep. Done one bit wider than the
    // duty so neither the add nor the subtract can wrap; the result is
    // clamped at the target so it never overshoots.
    function automatic logic [CntWidth-1:0] ramp_toward(
        input logic [CntWidth-1:0] cur,
        input logic [CntWidth-1:0] tgt
    );
        logic [CntWidth:0] cur_x;
        logic [CntWidth:0] tgt_x;
        logic [CntWidth:0] res;
        cur_x = {1'b0, cur};
        tgt_x = {1'b0, tgt};
        res   = tgt_x;
        if (RampStep != 0) begin
            if (tgt_x > cur_x) begin
                if ((tgt_x - cur_x) > StepX) res = cur_x + StepX;
            end else if (cur_x > tgt_x) begin
                if ((cur_x - tgt_x) > StepX) res = cur_x - StepX;
            end
        end
        return CntWidth'(res);
    endfunction

    // ------------------------------------------------------------------
    // Shared prescaler and period counter
    // ------------------------------------------------------------------
    logic [PscWidth-1:0] psc_q;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] period_q;
    logic                tick;
    logic                boundary;

    // >= rather than == so a prescale or period that shrinks below the
    // running count still terminates at the next tick instead of wrapping.
    assign tick     = (psc_q >= prescale_i);
    assign boundary = tick && (cnt_q >= period_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psc_q          <= '0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_start_o <= 1'b0;
        end else begin
            period_start_o <= boundary;
            psc_q          <= tick ? '0 : psc_q + 1'b1;
            if (boundary) begin
                cnt_q    <= '0;
                period_q <= period_i;
            end else if (tick) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel FSM, duty ramp and output register
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NumChannels; g++) begin : g_ch
        ch_state_e           state_q;
        ch_state_e           state_d;
        logic [CntWidth-1:0] duty_q;
        logic [CntWidth-1:0] duty_d;
        logic [KickW-1:0]    kick_q;
        logic [KickW-1:0]    kick_d;
        logic [CntWidth-1:0] duty_tgt;
        logic                pwm_q;

        assign duty_tgt = duty_i[g*CntWidth +: CntWidth];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_OFF;
                duty_q  <= '0;
                kick_q  <= '0;
            end else begin
                state_q <= state_d;
                duty_q  <= duty_d;
                kick_q  <= kick_d;
            end
        end

        always_comb begin
            state_d = state_q;
            duty_d  = duty_q;
            kick_d  = kick_q;
            if (boundary) begin
                case (state_q)
                    ST_OFF: begin
                        if (en_i[g]) begin
                            if (KickPeriods > 0) begin
                                state_d = ST_KICK;
                                kick_d  = '0;
                            end else begin
                                state_d = ST_RUN;
                                duty_d  = duty_tgt;
                            end
                        end
                    end
                    ST_KICK: begin
                        if (!en_i[g]) begin
                            state_d = ST_OFF;
                            duty_d  = '0;
                            kick_d  = '0;
                        end else if (kick_q == KickLast) begin
                            state_d = ST_RUN;
                            duty_d  = duty_tgt;
                            kick_d  = '0;
                        end else begin
                            kick_d = kick_q + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!en_i[g]) begin
                            state_d = ST_OFF;
                            duty_d  = '0;
                        end else begin
                            duty_d = ramp_toward(duty_q, duty_tgt);
                        end
                    end
                    default: begin
                        state_d = ST_OFF;
                        duty_d  = '0;
                        kick_d  = '0;
                    end
                endcase
            end
        end

        // cnt_q never exceeds period_q, so duty_q > period_q yields a
        // constant-high output and duty_q == 0 a constant-low one.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                pwm_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_KICK: pwm_q <= 1'b1;
                    ST_RUN:  pwm_q <= (cnt_q < duty_q);
                    default: pwm_q <= 1'b0;
                endcase
            end
        end

        assign pwm_o[g]       = pwm_q;
        assign busy_o[g]      = (state_q != ST_OFF);
        assign ramp_done_o[g] = (state_q == ST_RUN) && (duty_q == duty_tgt);
    end

endmodule
